div_unit: RTL

Iterative RV32M divide unit for the execute stage. It accepts one DIV/DIVU/REM/REMU request through a start/busy/valid handshake and computes one quotient bit per cycle with a radix-2 restoring algorithm. It returns a `CPU_WIDTH` result that follows RISC-V special-case rules. It sits beside `alu` and covers the multi-cycle operations the ALU does not. The pipeline stalls on `div_busy`.

---
 rtl/div_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with start/busy/valid handshake.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration phase.
`timescale 1ns/1ps

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module div_unit (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  div_start,
   input  logic [1:0]            div_op,
   input  logic [`CPU_WIDTH-1:0] div_src1,
   input  logic [`CPU_WIDTH-1:0] div_src2,
   input  logic                  div_flush,
   output logic                  div_busy,
   output logic                  div_valid,
   output logic [`CPU_WIDTH-1:0] div_res
);

   localparam int W  = `CPU_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_nxt;
   logic           rem_sel_q;
   logic           q_neg_q, r_neg_q;
   logic           dbz_q, ovf_q;
   logic [W-1:0]   rem_q, quo_q, dsr_q, src1_q;
   logic [CW-1:0]  cnt_q;

   logic           signed_op, s1_neg, s2_neg;
   logic           dbz_in, ovf_in, start_ok;
   logic [W-1:0]   abs1, abs2;
   logic [W:0]     shifted, diff;
   logic [W-1:0]   q_fix, r_fix, res_nxt;

   // Request decode: magnitudes and special-case flags are resolved once, at acceptance.
   assign signed_op = ~div_op[0];
   assign s1_neg    = signed_op & div_src1[W-1];
   assign s2_neg    = signed_op & div_src2[W-1];
   assign abs1      = s1_neg ? -div_src1 : div_src1;
   assign abs2      = s2_neg ? -div_src2 : div_src2;
   assign dbz_in    = (div_src2 == '0);
   assign ovf_in    = signed_op && (div_src1 == INT_MIN) && (div_src2 == '1);
   assign start_ok  = (state == IDLE) && div_start && !div_flush;
   assign div_busy  = (state != IDLE);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_ok) begin
`ifdef DIV_FAST_SPECIAL_EN
            state_nxt = (dbz_in || ovf_in) ? DONE : CALC;
`else
            state_nxt = CALC;
`endif
         end
         CALC:    if (cnt_q == CW'(W-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (div_flush) state_nxt = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // One restoring step: the W+1-bit trial subtract's sign bit decides keep vs restore.
   assign shifted = {rem_q, quo_q[W-1]};
   assign diff    = shifted - {1'b0, dsr_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_sel_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         src1_q    <= '0;
         cnt_q     <= '0;
      end else if (start_ok) begin
         rem_sel_q <= div_op[1];
         q_neg_q   <= s1_neg ^ s2_neg;
         r_neg_q   <= s1_neg;
         dbz_q     <= dbz_in;
         ovf_q     <= ovf_in;
         rem_q     <= '0;
         quo_q     <= abs1;
         dsr_q     <= abs2;
         src1_q    <= div_src1;
         cnt_q     <= '0;
      end else if (state == CALC) begin
         if (!diff[W]) begin
            rem_q <= diff[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b1};
         end else begin
            rem_q <= shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], 1'b0};
         end
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Sign correction, then the RISC-V special cases override the iterated value.
   assign q_fix = q_neg_q ? -quo_q : quo_q;
   assign r_fix = r_neg_q ? -rem_q : rem_q;

   always_comb begin
      res_nxt = rem_sel_q ? r_fix : q_fix;
      if (dbz_q)      res_nxt = rem_sel_q ? src1_q : '1;
      else if (ovf_q) res_nxt = rem_sel_q ? '0 : INT_MIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_valid <= 1'b0;
         div_res   <= '0;
      end else begin
         div_valid <= (state == DONE) && !div_flush;
         if ((state == DONE) && !div_flush) div_res <= res_nxt;
      end
   end

endmodule
